fetch_sequencer: RTL and testbench

- Controls the instruction-memory datapath: it owns the PC and issues synchronous ROM reads.
- It waits out the ROM read latency, latches the returned 32-bit word into an instruction register, and advances the PC.
- Fetches are triggered by a single-step pulse (from the key debouncer) or by a free-running mode. A jump/load port repositions the PC.
- Sits between the debounced front-panel inputs and the instruction ROM. Its registered outputs feed the LED byte-select display.

---
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues single-cycle ROM reads,
// waits out the ROM latency and latches the returned word into Inst_code.
module fetch_sequencer #(
    parameter int unsigned         ADDR_W   = 8,
    parameter int unsigned         MEM_LAT  = 1,
    parameter int unsigned         RUN_DIV  = 4,
    parameter logic [ADDR_W-1:0]   PC_LIMIT = 8'hFC
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Step,
    input  logic              Run,
    input  logic              Jump_en,
    input  logic [ADDR_W-1:0] Jump_addr,
    output logic              Mem_en,
    output logic [ADDR_W-3:0] Mem_addr,
    input  logic [31:0]       Mem_data,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] Inst_addr,
    output logic [31:0]       Inst_code,
    output logic              Inst_valid,
    output logic              Busy,
    output logic              Halted
);

    localparam int unsigned RCW = $clog2(RUN_DIV + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t           state;
    logic [RCW-1:0]   run_cnt;
    logic [2:0]       wait_cnt;
    logic             run_tick;
    logic             trigger;
    logic             jump_ok;
    logic [ADDR_W-1:0] jump_pc;

    assign Mem_addr = PC[ADDR_W-1:2];
    assign run_tick = Run && (run_cnt == RCW'(RUN_DIV - 1));
    assign trigger  = Step || run_tick;
    assign jump_ok  = Jump_en && (state == IDLE || state == HALT);
    assign jump_pc  = {Jump_addr[ADDR_W-1:2], 2'b00};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            PC         <= '0;
            Inst_addr  <= '0;
            Inst_code  <= '0;
            Inst_valid <= 1'b0;
            Mem_en     <= 1'b0;
            Busy       <= 1'b0;
            Halted     <= 1'b0;
            run_cnt    <= '0;
            wait_cnt   <= '0;
        end else begin
            Mem_en     <= 1'b0;
            Inst_valid <= 1'b0;

            // The run counter keeps counting while a fetch is in flight so the
            // run-mode cadence stays exactly RUN_DIV cycles.
            if (!Run || state == HALT || jump_ok)
                run_cnt <= '0;
            else if (run_cnt == RCW'(RUN_DIV - 1))
                run_cnt <= '0;
            else
                run_cnt <= run_cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (Jump_en) begin
                        PC <= jump_pc;
                    end else if (trigger) begin
                        state  <= ISSUE;
                        Mem_en <= 1'b1;
                        Busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    state    <= WAIT;
                    wait_cnt <= 3'(MEM_LAT);
                end
                WAIT: begin
                    if (wait_cnt == 3'd1) begin
                        Inst_code  <= Mem_data;
                        Inst_addr  <= PC;
                        Inst_valid <= 1'b1;
                        Busy       <= 1'b0;
                        if (PC == PC_LIMIT) begin
                            state  <= HALT;
                            Halted <= 1'b1;
                        end else begin
                            PC    <= PC + ADDR_W'(4);
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                HALT: begin
                    if (Jump_en) begin
                        PC     <= jump_pc;
                        Halted <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus pushes expected ROM reads and
// instruction-register updates; a negedge monitor pops and compares them.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        step;
    logic        run;
    logic        jump_en;
    logic [7:0]  jump_addr;
    logic        mem_en;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic [7:0]  pc;
    logic [7:0]  inst_addr;
    logic [31:0] inst_code;
    logic        inst_valid;
    logic        busy;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mem_cnt  = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] code;
        logic [7:0]  pc;
    } inst_t;

    typedef struct {
        logic [5:0] word;
        int         cyc;
    } mem_t;

    inst_t inst_q[$];
    mem_t  mem_q[$];

    fetch_sequencer #(
        .ADDR_W  (8),
        .MEM_LAT (1),
        .RUN_DIV (4),
        .PC_LIMIT(8'hFC)
    ) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Step      (step),
        .Run       (run),
        .Jump_en   (jump_en),
        .Jump_addr (jump_addr),
        .Mem_en    (mem_en),
        .Mem_addr  (mem_addr),
        .Mem_data  (mem_data),
        .PC        (pc),
        .Inst_addr (inst_addr),
        .Inst_code (inst_code),
        .Inst_valid(inst_valid),
        .Busy      (busy),
        .Halted    (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom(input logic [5:0] w);
        if (w == 6'd0) return 32'h2002_0005;
        return {8'hC0, 2'b00, w, 16'h1234};
    endfunction

    // One-cycle synchronous ROM
    always @(posedge clk) if (mem_en) mem_data <= rom(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (mem_en) begin
            mem_cnt++;
            if (mem_q.size() == 0) begin
                check("unexpected_mem_en", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                mem_t m;
                m = mem_q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(m.word));
                if (m.cyc >= 0) check("mem_en_cycle", 32'(cyc), 32'(m.cyc));
            end
        end
        if (inst_valid) begin
            if (inst_q.size() == 0) begin
                check("unexpected_inst_valid", inst_code, 32'hFFFF_FFFF);
            end else begin
                inst_t e;
                e = inst_q.pop_front();
                check("inst_code", inst_code, e.code);
                check("inst_addr", 32'(inst_addr), 32'(e.addr));
                check("pc_after_fetch", 32'(pc), 32'(e.pc));
            end
        end
    end

    task automatic push_mem(input logic [5:0] w, input int c);
        mem_t m;
        m.word = w;
        m.cyc  = c;
        mem_q.push_back(m);
    endtask

    task automatic push_inst(input logic [7:0] a, input logic [31:0] c, input logic [7:0] p);
        inst_t e;
        e.addr = a;
        e.code = c;
        e.pc   = p;
        inst_q.push_back(e);
    endtask

    task automatic pulse_step(input int len);
        @(posedge clk); #1 step = 1'b1;
        repeat (len) @(posedge clk);
        #1 step = 1'b0;
    endtask

    task automatic do_jump(input logic [7:0] a, input logic with_step);
        @(posedge clk); #1;
        jump_en   = 1'b1;
        jump_addr = a;
        step      = with_step;
        @(posedge clk); #1;
        jump_en = 1'b0;
        step    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        int c0;

        rst = 1'b1; step = 1'b0; run = 1'b0; jump_en = 1'b0; jump_addr = '0;
        idle(3);
        @(negedge clk);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_busy_halted", 32'({busy, halted, inst_valid}), 32'h0);
        check("rst_inst_code", inst_code, 32'h0);
        #1 rst = 1'b0;

        // Single step with latency checks
        push_mem(6'd0, -1);
        push_inst(8'h00, 32'h2002_0005, 8'h04);
        pulse_step(1);
        @(negedge clk);
        check("t1_mem_en_T1", 32'({mem_en, busy}), 32'h3);
        check("t1_mem_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        check("t1_wait_T2", 32'({mem_en, busy, inst_valid}), 32'h2);
        @(negedge clk);
        check("t1_valid_T3", 32'({inst_valid, busy}), 32'h2);
        idle(2);

        // Step held through Busy: exactly one fetch
        base = mem_cnt;
        push_mem(6'd1, -1);
        push_inst(8'h04, 32'hC001_1234, 8'h08);
        pulse_step(3);
        idle(4);
        check("t2_one_fetch", 32'(mem_cnt - base), 32'd1);
        check("t2_pc", 32'(pc), 32'h08);

        // Free-run for 20 cycles from PC 0
        do_jump(8'h00, 1'b0);
        idle(1);
        @(posedge clk); #1;
        run = 1'b1;
        c0  = cyc;
        for (int i = 0; i < 5; i++) push_mem(6'(i), c0 + 4 * (i + 1));
        push_inst(8'h00, 32'h2002_0005, 8'h04);
        push_inst(8'h04, 32'hC001_1234, 8'h08);
        push_inst(8'h08, 32'hC002_1234, 8'h0C);
        push_inst(8'h0C, 32'hC003_1234, 8'h10);
        push_inst(8'h10, 32'hC004_1234, 8'h14);
        repeat (20) @(posedge clk);
        #1 run = 1'b0;
        idle(5);
        check("t3_pc", 32'(pc), 32'h14);

        // Jump with simultaneous Step: jump wins, step dropped
        base = mem_cnt;
        do_jump(8'h27, 1'b1);
        idle(3);
        check("t4_jump_pc", 32'(pc), 32'h24);
        check("t4_no_fetch", 32'(mem_cnt - base), 32'd0);
        push_mem(6'd9, -1);
        push_inst(8'h24, 32'hC009_1234, 8'h28);
        pulse_step(1);
        idle(4);

        // Fetch up to PC_LIMIT and halt
        do_jump(8'hF8, 1'b0);
        push_mem(6'h3E, -1);
        push_inst(8'hF8, 32'hC03E_1234, 8'hFC);
        pulse_step(1);
        idle(4);
        push_mem(6'h3F, -1);
        push_inst(8'hFC, 32'hC03F_1234, 8'hFC);
        pulse_step(1);
        idle(4);
        @(negedge clk);
        check("t5_halted", 32'({halted, busy}), 32'h2);
        check("t5_pc_held", 32'(pc), 32'hFC);
        base = mem_cnt;
        #1 run = 1'b1;
        pulse_step(3);
        idle(10);
        run = 1'b0;
        idle(2);
        check("t5_halt_blocks", 32'(mem_cnt - base), 32'd0);
        check("t5_still_halted", 32'(halted), 32'h1);
        do_jump(8'h00, 1'b0);
        @(negedge clk);
        check("t5_unhalt", 32'({halted, pc}), 32'h0);

        // Reset in the WAIT cycle aborts the fetch
        push_mem(6'd0, -1);
        pulse_step(1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_outputs", 32'({mem_en, inst_valid, busy, halted, pc}), 32'h0);
        check("t6_inst_code", inst_code, 32'h0);
        check("t6_inst_addr", 32'(inst_addr), 32'h0);
        idle(5);
        check("t6_code_stays", inst_code, 32'h0);

        check("inst_q_drained", 32'(inst_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
